// File: rtl/regs_pkg.sv
// Shared constants and types for the multi-port register file.
package regs_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Default-width architectural register word
    typedef logic [XLEN_DEF-1:0] word_t;

    // Address width for an n-entry register file (at least one bit)
    function automatic int unsigned addr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regs_wr_sel.sv
// Write-port priority selector: for one address, reports whether any enabled
// write port targets it and returns the data of the highest-index such port.
module regs_wr_sel
    import regs_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned AW   = 5,
    parameter int unsigned NWR  = 2
) (
    input  logic [AW-1:0]       addr,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                hit_c,
    output logic [XLEN-1:0]     data_c
);

    // Ascending scan so a later (higher-index) match overrides earlier ones
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        for (int k = 0; k < int'(NWR); k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == addr)) begin
                hit_c  = 1'b1;
                data_c = wr_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regs_mp.sv
// Multi-port register file with a per-register pending scoreboard.
// x0 is hardwired to zero; addresses at or above NREGS read as zero and
// are ignored for writes and reserves.
// Optional feature macro: REGS_MP_BYPASS_EN -- a read that coincides with a
// write to the same register returns the new data and the post-edge pending
// bit instead of the pre-edge state.
module regs_mp
    import regs_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = 2,
    parameter  int unsigned NWR   = 2,
    localparam int unsigned AW    = addr_bits(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rs_rd_en,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_rd_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      rd_wr_en,
    input  logic [NWR*AW-1:0]   rd_addr,
    input  logic [NWR*XLEN-1:0] rd_wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    pending
);

    logic [XLEN-1:0]  regs       [NREGS];
    logic [NREGS-1:0] wr_hit_c;
    logic [XLEN-1:0]  wr_data_c  [NREGS];
    logic [NREGS-1:0] pend_nxt_c;
    logic [XLEN-1:0]  rd_val_c   [NRD];
    logic [NRD-1:0]   busy_val_c;

    // One write selector per architectural register
    for (genvar i = 0; i < int'(NREGS); i++) begin : g_reg_sel
        regs_wr_sel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_sel (
            .addr    (AW'(i)),
            .wr_en   (rd_wr_en),
            .wr_addr (rd_addr),
            .wr_data (rd_wr_data),
            .hit_c   (wr_hit_c[i]),
            .data_c  (wr_data_c[i])
        );
    end

`ifdef REGS_MP_BYPASS_EN
    logic [NRD-1:0]  byp_hit_c;
    logic [XLEN-1:0] byp_data_c [NRD];

    // One write selector per read port for same-edge forwarding
    for (genvar p = 0; p < int'(NRD); p++) begin : g_byp_sel
        regs_wr_sel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_sel (
            .addr    (rs_addr[p*AW +: AW]),
            .wr_en   (rd_wr_en),
            .wr_addr (rd_addr),
            .wr_data (rd_wr_data),
            .hit_c   (byp_hit_c[p]),
            .data_c  (byp_data_c[p])
        );
    end
`endif

    // Next scoreboard: writes clear, reserve sets afterwards so it wins
    always_comb begin
        pend_nxt_c = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (i == 0) begin
                pend_nxt_c[i] = 1'b0;
            end else begin
                pend_nxt_c[i] = (pending[i] & ~wr_hit_c[i])
                              | (rsv_en && (rsv_addr == AW'(i)));
            end
        end
    end

    // Read mux per port; x0 and out-of-range addresses never match a slot
    always_comb begin
        for (int p = 0; p < int'(NRD); p++) begin
            rd_val_c[p]   = '0;
            busy_val_c[p] = 1'b0;
            for (int i = 1; i < int'(NREGS); i++) begin
                if (rs_addr[p*AW +: AW] == AW'(i)) begin
`ifdef REGS_MP_BYPASS_EN
                    if (byp_hit_c[p]) begin
                        rd_val_c[p]   = byp_data_c[p];
                        busy_val_c[p] = pend_nxt_c[i];
                    end else begin
                        rd_val_c[p]   = regs[i];
                        busy_val_c[p] = pending[i];
                    end
`else
                    rd_val_c[p]   = regs[i];
                    busy_val_c[p] = pending[i];
`endif
                end
            end
        end
    end

    // Register array update; slot 0 stays at its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if ((i != 0) && wr_hit_c[i]) begin
                    regs[i] <= wr_data_c[i];
                end
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt_c;
        end
    end

    // Registered read data and busy flag, held while the port is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_rd_data <= '0;
            rs_busy    <= '0;
        end else begin
            for (int p = 0; p < int'(NRD); p++) begin
                if (rs_rd_en[p]) begin
                    rs_rd_data[p*XLEN +: XLEN] <= rd_val_c[p];
                    rs_busy[p]                 <= busy_val_c[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: directed vector table, async reset
// sequence, then randomized traffic against a state-level reference model.
module tb_regs_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

`ifdef REGS_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic [NRD-1:0]      rs_rd_en;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_rd_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      rd_wr_en;
    logic [NWR*AW-1:0]   rd_addr;
    logic [NWR*XLEN-1:0] rd_wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NREGS-1:0]    pending;

    regs_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_rd_en   (rs_rd_en),
        .rs_addr    (rs_addr),
        .rs_rd_data (rs_rd_data),
        .rs_busy    (rs_busy),
        .rd_wr_en   (rd_wr_en),
        .rd_addr    (rd_addr),
        .rd_wr_data (rd_wr_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: architectural registers, scoreboard, read outputs
    logic [31:0]      m_x [NREGS];
    logic [NREGS-1:0] m_pend;
    logic [31:0]      m_rd [NRD];
    logic [NRD-1:0]   m_busy;

    typedef struct {
        logic [1:0]  rd_en;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  wr_en;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  rsa;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_busy;
        logic [31:0] e_pend;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_x[i] = 32'h0;
        m_pend = '0;
        for (int p = 0; p < NRD; p++) m_rd[p] = 32'h0;
        m_busy = '0;
    endtask

    // One rising edge of the architecture: bypass reads see post-edge state
    task automatic model_edge();
        logic [31:0]      nx [NREGS];
        logic [NREGS-1:0] np;
        int               a;
        bit               hit;
        nx = m_x;
        np = m_pend;
        for (int k = 0; k < NWR; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            if (rd_wr_en[k] && a != 0 && a < NREGS) begin
                nx[a] = rd_wr_data[k*XLEN +: XLEN];
                np[a] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != 5'd0 && int'(rsv_addr) < NREGS) np[rsv_addr] = 1'b1;
        for (int p = 0; p < NRD; p++) begin
            if (rs_rd_en[p]) begin
                a = int'(rs_addr[p*AW +: AW]);
                if (a == 0 || a >= NREGS) begin
                    m_rd[p]   = 32'h0;
                    m_busy[p] = 1'b0;
                end else begin
                    hit = 1'b0;
                    for (int k = 0; k < NWR; k++)
                        if (rd_wr_en[k] && int'(rd_addr[k*AW +: AW]) == a) hit = 1'b1;
                    if (BYP && hit) begin
                        m_rd[p]   = nx[a];
                        m_busy[p] = np[a];
                    end else begin
                        m_rd[p]   = m_x[a];
                        m_busy[p] = m_pend[a];
                    end
                end
            end
        end
        m_x    = nx;
        m_pend = np;
    endtask

    task automatic drive_idle();
        rs_rd_en   = '0;
        rs_addr    = '0;
        rd_wr_en   = '0;
        rd_addr    = '0;
        rd_wr_data = '0;
        rsv_en     = 1'b0;
        rsv_addr   = '0;
    endtask

    task automatic check_model(input string tag);
        check_val({tag, " rd0"},  rs_rd_data[31:0],  m_rd[0]);
        check_val({tag, " rd1"},  rs_rd_data[63:32], m_rd[1]);
        check_val({tag, " busy"}, 32'(rs_busy),      32'(m_busy));
        check_val({tag, " pend"}, pending,           m_pend);
    endtask

    initial begin
        logic [31:0] r9, r12, r13;
        logic        b12, b13;
        string       tag;

        r9  = BYP ? 32'hB  : 32'hA;
        r12 = BYP ? 32'h33 : 32'h0;
        r13 = BYP ? 32'h44 : 32'h33;
        b12 = BYP ? 1'b0 : 1'b1;
        b13 = BYP ? 1'b1 : 1'b0;

        //             rd_en  ra0   ra1   wr_en  wa0   wa1   wd0            wd1       rsv   rsa   e_rd0          e_rd1          e_busy       e_pend
        tbl[0]  = '{2'b00, 5'd0, 5'd0,  2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,    1'b0, 5'd0, 32'h0,         32'h0,         2'b00,       32'h0};
        tbl[1]  = '{2'b10, 5'd0, 5'd5,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 32'h0,         32'hDEADBEEF,  2'b00,       32'h0};
        tbl[2]  = '{2'b00, 5'd0, 5'd0,  2'b01, 5'd0, 5'd0, 32'h1234,     32'h0,    1'b0, 5'd0, 32'h0,         32'hDEADBEEF,  2'b00,       32'h0};
        tbl[3]  = '{2'b01, 5'd0, 5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 32'h0,         32'hDEADBEEF,  2'b00,       32'h0};
        tbl[4]  = '{2'b00, 5'd0, 5'd0,  2'b11, 5'd7, 5'd7, 32'h11,       32'h22,   1'b0, 5'd0, 32'h0,         32'hDEADBEEF,  2'b00,       32'h0};
        tbl[5]  = '{2'b01, 5'd7, 5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 32'h22,        32'hDEADBEEF,  2'b00,       32'h0};
        tbl[6]  = '{2'b00, 5'd0, 5'd0,  2'b01, 5'd9, 5'd0, 32'hA,        32'h0,    1'b0, 5'd0, 32'h22,        32'hDEADBEEF,  2'b00,       32'h0};
        tbl[7]  = '{2'b01, 5'd9, 5'd0,  2'b10, 5'd0, 5'd9, 32'h0,        32'hB,    1'b0, 5'd0, r9,            32'hDEADBEEF,  2'b00,       32'h0};
        tbl[8]  = '{2'b10, 5'd0, 5'd9,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0, r9,            32'hB,         2'b00,       32'h0};
        tbl[9]  = '{2'b00, 5'd0, 5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1, 5'd3, r9,            32'hB,         2'b00,       32'h8};
        tbl[10] = '{2'b01, 5'd3, 5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 32'h0,         32'hB,         2'b01,       32'h8};
        tbl[11] = '{2'b10, 5'd0, 5'd3,  2'b01, 5'd3, 5'd0, 32'h33,       32'h0,    1'b0, 5'd0, 32'h0,         r12,           {b12, 1'b1}, 32'h0};
        tbl[12] = '{2'b01, 5'd3, 5'd0,  2'b10, 5'd0, 5'd3, 32'h0,        32'h44,   1'b1, 5'd3, r13,           r12,           {b12, b13},  32'h8};
        tbl[13] = '{2'b00, 5'd5, 5'd7,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0, r13,           r12,           {b12, b13},  32'h8};
        tbl[14] = '{2'b11, 5'd3, 5'd31, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 32'h44,        32'h0,         2'b01,       32'h8};
        tbl[15] = '{2'b00, 5'd0, 5'd0,  2'b01, 5'd0, 5'd0, 32'h5555,     32'h0,    1'b1, 5'd0, 32'h44,        32'h0,         2'b01,       32'h8};

        // Reset state
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int v = 0; v < NVEC; v++) begin
            rs_rd_en   = tbl[v].rd_en;
            rs_addr    = {tbl[v].ra1, tbl[v].ra0};
            rd_wr_en   = tbl[v].wr_en;
            rd_addr    = {tbl[v].wa1, tbl[v].wa0};
            rd_wr_data = {tbl[v].wd1, tbl[v].wd0};
            rsv_en     = tbl[v].rsv;
            rsv_addr   = tbl[v].rsa;
            model_edge();
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d", v);
            check_val({tag, " rd0"},  rs_rd_data[31:0],  tbl[v].e_rd0);
            check_val({tag, " rd1"},  rs_rd_data[63:32], tbl[v].e_rd1);
            check_val({tag, " busy"}, 32'(rs_busy),      32'(tbl[v].e_busy));
            check_val({tag, " pend"}, pending,           tbl[v].e_pend);
        end

        // Asynchronous reset in the middle of a write to x4
        rs_rd_en   = 2'b11;
        rs_addr    = {5'd4, 5'd4};
        rd_wr_en   = 2'b01;
        rd_addr    = {5'd0, 5'd4};
        rd_wr_data = {32'h0, 32'h4444};
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async rd0",  rs_rd_data[31:0],  32'h0);
        check_val("async rd1",  rs_rd_data[63:32], 32'h0);
        check_val("async busy", 32'(rs_busy),      32'h0);
        check_val("async pend", pending,           32'h0);
        @(posedge clk);
        #1;
        check_model("in_reset");
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        rs_rd_en = 2'b11;
        rs_addr  = {5'd3, 5'd4};
        model_edge();
        @(posedge clk);
        #1;
        check_val("post_rst x4", rs_rd_data[31:0],  32'h0);
        check_val("post_rst x3", rs_rd_data[63:32], 32'h0);
        check_model("post_rst");

        // Randomized traffic, addresses biased to collide
        for (int c = 0; c < 400; c++) begin
            rs_rd_en = 2'($urandom_range(0, 3));
            for (int p = 0; p < NRD; p++)
                rs_addr[p*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                                  : 5'($urandom_range(0, 7));
            rd_wr_en = 2'($urandom_range(0, 3));
            for (int k = 0; k < NWR; k++) begin
                rd_addr[k*AW +: AW]      = 5'($urandom_range(0, 7));
                rd_wr_data[k*XLEN +: XLEN] = $urandom;
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            model_edge();
            @(posedge clk);
            #1;
            check_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
